// File: rtl/clock_pkg.sv
// Shared constants, types and helpers for the digital clock front-end.
//   ms_to_cycles : milliseconds -> clk cycles (never below 1)
//   cnt_width    : counter width for a terminal count (never below 1)
//   rpt_state_t  : per-channel auto-repeat state
//   BTN_*        : button channel indices
package clock_pkg;

  localparam int unsigned BTN_RST  = 0;
  localparam int unsigned BTN_MODE = 1;
  localparam int unsigned BTN_UP   = 2;
  localparam int unsigned BTN_DW   = 3;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    int unsigned cyc;
    cyc = (clk_hz / 1000) * ms;
    return (cyc == 0) ? 1 : cyc;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce, press pulse and auto-repeat.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   raw        : raw button, asynchronous, active-low
//   db         : debounced level, active-low
//   press      : 1-cycle pulse on accepted press
//   step       : press pulse plus auto-repeat pulses (when REPEAT_EN)
module btn_channel
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYC    = 4,
  parameter int unsigned HOLD_CYC  = 20,
  parameter int unsigned RPT_CYC   = 5,
  parameter bit          REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic press,
  output logic step
);

  localparam int unsigned DB_W = cnt_width(DB_CYC);
  localparam int unsigned H_W  = cnt_width((HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC);

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] cnt;
  logic [H_W-1:0]  hcnt;
  rpt_state_t      state;

  logic accept;
  logic fall;
  logic rise;

  // accept fires on the edge where a differing level has been stable for DB_CYC samples
  assign accept = (s2 != db) && (cnt == DB_W'(DB_CYC - 1));
  assign fall   = accept && !s2;
  assign rise   = accept && s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
      step  <= 1'b0;
      hcnt  <= '0;
      state <= REL;
    end else begin
      s1 <= raw;
      s2 <= s1;

      // any agreeing sample restarts the debounce count
      if (s2 == db) begin
        cnt <= '0;
      end else if (accept) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end

      press <= fall;
      step  <= 1'b0;

      // release has priority over any terminal count in the same cycle
      if (rise) begin
        state <= REL;
        hcnt  <= '0;
      end else begin
        case (state)
          REL: begin
            if (fall) begin
              state <= HOLD;
              hcnt  <= '0;
              step  <= 1'b1;
            end
          end
          HOLD: begin
            // non-repeating channels park here until release
            if (REPEAT_EN) begin
              if (hcnt == H_W'(HOLD_CYC - 1)) begin
                step  <= 1'b1;
                hcnt  <= '0;
                state <= RPT;
              end else begin
                hcnt <= hcnt + H_W'(1);
              end
            end
          end
          RPT: begin
            if (hcnt == H_W'(RPT_CYC - 1)) begin
              step <= 1'b1;
              hcnt <= '0;
            end else begin
              hcnt <= hcnt + H_W'(1);
            end
          end
          default: begin
            state <= REL;
            hcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton front-end: synchronise, debounce, press pulses and auto-repeat steps
// for every board button.
// Ports:
//   clk, rst_n : clock, synchronous active-low power-on reset
//   btn_raw    : raw buttons, asynchronous, active-low
//   btn_db     : debounced levels, active-low
//   btn_press  : 1-cycle pulse per accepted press
//   btn_step   : press pulses OR auto-repeat pulses (REPEAT_MASK channels)
module btn_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned       N_BTN       = 4,
  parameter int unsigned       CLK_HZ      = 50_000_000,
  parameter int unsigned       DEBOUNCE_MS = 20,
  parameter int unsigned       HOLD_MS     = 500,
  parameter int unsigned       REPEAT_MS   = 100,
  parameter logic [N_BTN-1:0]  REPEAT_MASK = N_BTN'(4'b1100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_step
);

  localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned HOLD_CYC = ms_to_cycles(CLK_HZ, HOLD_MS);
  localparam int unsigned RPT_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYC   (DB_CYC),
      .HOLD_CYC (HOLD_CYC),
      .RPT_CYC  (RPT_CYC),
      .REPEAT_EN(REPEAT_MASK[i])
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .db   (btn_db[i]),
      .press(btn_press[i]),
      .step (btn_step[i])
    );
  end

endmodule
